// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB packet transmitter: FSM encoding,
// framing markers and bus widths.
`timescale 1ns/1ps
package usb_tx_pkg;

  localparam int USB_W = 32;
  localparam int EVT_W = 64;
  localparam int SEQ_W = 16;

  localparam logic [7:0] HDR_MARK = 8'hA5;
  localparam logic [7:0] TRL_MARK = 8'hE7;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR0 = 3'd1,
    ST_HDR1 = 3'd2,
    ST_PAYH = 3'd3,
    ST_PAYL = 3'd4,
    ST_REQ  = 3'd5,
    ST_TRL0 = 3'd6,
    ST_TRL1 = 3'd7
  } state_e;

endpackage

// File: rtl/usb_tx_checksum.sv
// Running 32-bit XOR of both halves of each payload word; clear has priority
// over accumulate so the packet-done cycle always leaves a zero register.
`timescale 1ns/1ps
module usb_tx_checksum
  import usb_tx_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             acc_en_i,
  input  logic [EVT_W-1:0] word_i,
  output logic [USB_W-1:0] sum_o
);

  logic [USB_W-1:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (clear_i) begin
      sum_d = '0;
    end else if (acc_en_i) begin
      sum_d = sum_q ^ word_i[EVT_W-1:USB_W] ^ word_i[USB_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/usb_packet_tx.sv
// Frames 64-bit event words into 32-bit USB packets (header x2, payload,
// trailer). Define USB_CHECKSUM_EN to append the XOR checksum word (TRL1).
`timescale 1ns/1ps
module usb_packet_tx
  import usb_tx_pkg::*;
#(
  parameter int unsigned PKT_WORDS = 16,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tx_enable,
  input  logic [23:0]      run_number,
  output logic             transmit_request,
  input  logic             transmit_complete,
  input  logic [EVT_W-1:0] word_in,
  output logic [USB_W-1:0] usb_data,
  output logic             usb_valid,
  input  logic             usb_ready,
  output logic [SEQ_W-1:0] pkt_seq,
  output logic             busy,
  output logic             proto_err,
  output state_e           dbg_state_o
);

  localparam logic [15:0] PKT_LEN  = 16'(PKT_WORDS);
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT - 1);

  // Handshakes: upstream word is taken on transmit_complete only while
  // transmit_request is high; a USB word moves on a clock edge with
  // usb_valid && usb_ready, and usb_data holds steady until then.

  state_e           state_q, state_d;
  logic [EVT_W-1:0] word_q, word_d;
  logic [23:0]      run_q, run_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [31:0]      tmo_q, tmo_d;
  logic [SEQ_W-1:0] pkt_seq_q, pkt_seq_d;
  logic             req_q, req_d;
  logic             perr_q, perr_d;

  logic capture, xfer, pkt_done, pay_done;

  assign capture  = transmit_complete && req_q;
  assign xfer     = usb_valid && usb_ready;
  assign pay_done = (state_q == ST_PAYL) && xfer;

`ifdef USB_CHECKSUM_EN
  logic [USB_W-1:0] cs_sum;

  assign pkt_done = (state_q == ST_TRL1) && xfer;

  usb_tx_checksum u_checksum (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (pkt_done),
    .acc_en_i (pay_done),
    .word_i   (word_q),
    .sum_o    (cs_sum)
  );
`else
  assign pkt_done = (state_q == ST_TRL0) && xfer;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (capture) state_d = ST_HDR0;
      ST_HDR0: if (xfer) state_d = ST_HDR1;
      ST_HDR1: if (xfer) state_d = ST_PAYH;
      ST_PAYH: if (xfer) state_d = ST_PAYL;
      ST_PAYL: begin
        if (xfer) begin
          if ((cnt_q + 16'd1) == PKT_LEN || !tx_enable) state_d = ST_TRL0;
          else                                           state_d = ST_REQ;
        end
      end
      // A word arriving in the expiry cycle is still taken.
      ST_REQ: begin
        if (capture)                state_d = ST_PAYH;
        else if (!tx_enable)        state_d = ST_TRL0;
        else if (tmo_q == TMO_LAST) state_d = ST_TRL0;
      end
`ifdef USB_CHECKSUM_EN
      ST_TRL0: if (xfer) state_d = ST_TRL1;
      ST_TRL1: if (xfer) state_d = ST_IDLE;
`else
      ST_TRL0: if (xfer) state_d = ST_IDLE;
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    usb_valid = 1'b0;
    usb_data  = '0;
    case (state_q)
      ST_HDR0: begin usb_valid = 1'b1; usb_data = {HDR_MARK, run_q};           end
      ST_HDR1: begin usb_valid = 1'b1; usb_data = {pkt_seq_q, PKT_LEN};        end
      ST_PAYH: begin usb_valid = 1'b1; usb_data = word_q[EVT_W-1:USB_W];       end
      ST_PAYL: begin usb_valid = 1'b1; usb_data = word_q[USB_W-1:0];           end
      ST_TRL0: begin usb_valid = 1'b1; usb_data = {TRL_MARK, 8'h00, cnt_q};    end
`ifdef USB_CHECKSUM_EN
      ST_TRL1: begin usb_valid = 1'b1; usb_data = cs_sum;                      end
`endif
      default: begin usb_valid = 1'b0; usb_data = '0;                          end
    endcase
  end

  // Request is registered from the next state, so it is high exactly while
  // the FSM sits in REQ, or in IDLE one cycle after tx_enable rises.
  always_comb begin
    word_d    = word_q;
    run_d     = run_q;
    cnt_d     = cnt_q;
    tmo_d     = '0;
    pkt_seq_d = pkt_seq_q;
    perr_d    = perr_q || (transmit_complete && !req_q);
    req_d     = ((state_d == ST_IDLE) && tx_enable) || (state_d == ST_REQ);
    if (capture) word_d = word_in;
    if (capture && state_q == ST_IDLE) run_d = run_number;
    if (pay_done) cnt_d = cnt_q + 16'd1;
    if (state_q == ST_REQ && !capture) tmo_d = tmo_q + 32'd1;
    if (pkt_done) begin
      cnt_d     = '0;
      pkt_seq_d = pkt_seq_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_q    <= '0;
      run_q     <= '0;
      cnt_q     <= '0;
      tmo_q     <= '0;
      pkt_seq_q <= '0;
      req_q     <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      word_q    <= word_d;
      run_q     <= run_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
      pkt_seq_q <= pkt_seq_d;
      req_q     <= req_d;
      perr_q    <= perr_d;
    end
  end

  assign transmit_request = req_q;
  assign pkt_seq          = pkt_seq_q;
  assign proto_err        = perr_q;
  assign busy             = (state_q != ST_IDLE);
  assign dbg_state_o      = state_q;

endmodule
